// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: IMEM port and IF/ID handshake between fetch, instruction memory and decoder.
interface pc_fetch_unit_if;
    logic [31:0] PC_Out;
    logic [31:0] instruction;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    modport master (output PC_Out, if_valid, if_pc, if_instr, input instruction, if_ready);
    modport slave  (input PC_Out, if_valid, if_pc, if_instr, output instruction, if_ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, IF/ID holding register with valid/ready, redirect flush and sticky fetch faults.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_unit_if.master   bus,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              fetch_fault,
    output logic [31:0]       fault_pc,
    output logic [31:0]       fetch_count
);
    typedef enum logic [1:0] {WARMUP, RUN, FAULT} state_t;
    localparam logic [32:0] DEPTH = 33'(IMEM_DEPTH);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
    logic [31:0] fault_pc_q, fault_pc_d, count_q, count_d;
    logic        valid_q, valid_d, fault_q, fault_d;
    logic        hs, adv, tgt_bad, seq_oor;
    logic [32:0] pc_inc;
    always_comb begin
        hs         = valid_q && bus.if_ready;
        adv        = !stall && (!valid_q || bus.if_ready);
        // carry out of the +4 lands in the word index, so a wrap is always out of range
        pc_inc     = {1'b0, pc_q} + 33'd4;
        seq_oor    = {2'b0, pc_inc[32:2]} >= DEPTH;
        tgt_bad    = (redirect_target[1:0] != 2'b00) || ({3'b0, redirect_target[31:2]} >= DEPTH);
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q + {31'b0, hs};
        if (state_q != FAULT && redirect_valid) begin
            valid_d = 1'b0;
            if (tgt_bad) begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_target;
            end else begin
                state_d = RUN;
                pc_d    = redirect_target;
            end
        end else if (state_q == WARMUP) begin
            state_d = RUN;
        end else if (state_q == RUN && adv) begin
            valid_d    = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = bus.instruction;
            if (seq_oor) begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = pc_inc[31:0];
            end else begin
                pc_d = pc_inc[31:0];
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WARMUP;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end
    assign bus.PC_Out   = pc_q;
    assign bus.if_valid = valid_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.if_instr = if_instr_q;
    assign fetch_fault  = fault_q;
    assign fault_pc     = fault_pc_q;
    assign fetch_count  = count_q;
endmodule
